video_line_mem_ctrl: RTL and testbench

Sequencer for the 1-bit x 256 shift-register line store `fifo_1bit_256depth`, used as a one-line video buffer. It drives the store's shift enable and serial input, and recirculates data_out so contents persist across lines. It streams one pixel per tick during active video. Single-bit host writes are merged in as a rotation passes the target address: during scanout when the address comes by, or by a full 256-shift rotation during blanking.

---
 rtl/video_mem_pkg.sv | 16 +
 rtl/video_wr_slot.sv | 60 ++++++
 rtl/video_line_mem_ctrl.sv | 125 ++++++++++++
 tb/tb_video_line_mem_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_mem_pkg.sv
// Shared definitions for the one-line video buffer sequencer.
//   DEFAULT_DEPTH  - bits in the 1-bit shift-register line store (power of two)
//   DEFAULT_ADDR_W - log2(DEFAULT_DEPTH), width of position / write address
//   state_t        - sequencer states
package video_mem_pkg;

    localparam int DEFAULT_DEPTH  = 256;
    localparam int DEFAULT_ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        ROTATE = 2'd2
    } state_t;

endpackage

// File: rtl/video_wr_slot.sv
// Single-entry holding register for host bit writes.
//   clk, rst      - clock, synchronous active-high reset
//   wr_req        - host request; captured when the slot is empty
//   wr_addr/data  - bit index and value to write
//   commit        - the held write was shifted into the store this cycle
//   full          - slot holds a pending write
//   addr_held     - pending write address
//   data_held     - pending write value
//   wr_ready      - slot empty (a request this cycle is accepted)
//   wr_done       - one-cycle pulse the cycle after commit
module video_wr_slot #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_data,
    input  logic              commit,
    output logic              full,
    output logic [ADDR_W-1:0] addr_held,
    output logic              data_held,
    output logic              wr_ready,
    output logic              wr_done
);

    logic              r_full;
    logic [ADDR_W-1:0] r_addr;
    logic              r_data;
    logic              r_done;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_addr <= '0;
            r_data <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= commit;
            // commit can only happen while full, capture only while empty,
            // so the two never coincide.
            if (commit) begin
                r_full <= 1'b0;
            end else if (wr_req && !r_full) begin
                r_full <= 1'b1;
                r_addr <= wr_addr;
                r_data <= wr_data;
            end
        end
    end

    assign full      = r_full;
    assign addr_held = r_addr;
    assign data_held = r_data;
    assign wr_ready  = ~r_full;
    assign wr_done   = r_done;

endmodule

// File: rtl/video_line_mem_ctrl.sv
// Sequencer for a 1-bit x DEPTH shift-register line store used as a
// one-line video buffer. Data recirculates from fifo_dout to fifo_din so
// the line persists; a pending host write replaces the recirculated bit
// when its address passes the head, either during scanout or during a
// full-length rotation in blanking.
//   line_start, pix_tick, blank_window - video timing inputs
//   wr_req/wr_addr/wr_data, wr_ready, wr_done - host single-bit write
//   pixel_out - registered scanout pixel; busy - not IDLE
//   overrun   - sticky: line_start arrived while not IDLE
//   fifo_enable/fifo_din/fifo_dout/fifo_rst_n - line store interface
module video_line_mem_ctrl #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_start,
    input  logic              pix_tick,
    input  logic              blank_window,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_data,
    output logic              wr_ready,
    output logic              wr_done,
    output logic              pixel_out,
    output logic              busy,
    output logic              overrun,
    output logic              fifo_enable,
    output logic              fifo_din,
    input  logic              fifo_dout,
    output logic              fifo_rst_n
);
    import video_mem_pkg::*;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pos;
    logic              r_pixel;
    logic              r_overrun;

    logic              w_shift;
    logic              w_last;
    logic              w_hit;
    logic              w_commit;
    logic              w_full;
    logic [ADDR_W-1:0] w_addr_held;
    logic              w_data_held;

    video_wr_slot #(.ADDR_W(ADDR_W)) u_wr_slot (
        .clk       (clk),
        .rst       (rst),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .commit    (w_commit),
        .full      (w_full),
        .addr_held (w_addr_held),
        .data_held (w_data_held),
        .wr_ready  (wr_ready),
        .wr_done   (wr_done)
    );

    assign w_shift  = ((r_state == SCAN) && pix_tick) || (r_state == ROTATE);
    assign w_last   = (r_pos == ADDR_W'(DEPTH - 1));
    assign w_hit    = w_full && (r_pos == w_addr_held);
    assign w_commit = w_shift && w_hit;

    // NOTE: the default assignment before the case keeps every path driven,
    // so no latch is inferred for the next-state value.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                // A line start wins over starting a blanking rotation.
                if (line_start) begin
                    w_state_nxt = SCAN;
                end else if (w_full && blank_window) begin
                    w_state_nxt = ROTATE;
                end
            end
            SCAN: begin
                if (pix_tick && w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            ROTATE: begin
                // Always a full DEPTH rotation so the head returns to bit 0.
                if (w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pos     <= '0;
            r_pixel   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_shift) begin
                r_pos <= r_pos + 1'b1;
            end
            if (r_state != SCAN) begin
                r_pixel <= 1'b0;
            end else if (pix_tick) begin
                r_pixel <= fifo_dout;
            end
            if (line_start && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign fifo_enable = w_shift;
    assign fifo_din    = w_commit ? w_data_held : fifo_dout;
    assign fifo_rst_n  = ~rst;
    assign pixel_out   = r_pixel;
    assign busy        = (r_state != IDLE);
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_video_line_mem_ctrl.sv
// Directed bench for video_line_mem_ctrl with a behavioural model of the
// 1-bit x 256 shift-register line store attached to the fifo_* pins.
module tb_video_line_mem_ctrl;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              line_start;
    logic              pix_tick;
    logic              blank_window;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_data;
    logic              wr_ready;
    logic              wr_done;
    logic              pixel_out;
    logic              busy;
    logic              overrun;
    logic              fifo_enable;
    logic              fifo_din;
    logic              fifo_dout;
    logic              fifo_rst_n;

    int vectors     = 0;
    int miscompares = 0;
    int en_cnt      = 0;
    int done_cnt    = 0;

    logic [DEPTH-1:0] store;

    always #5 clk = ~clk;

    video_line_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .line_start   (line_start),
        .pix_tick     (pix_tick),
        .blank_window (blank_window),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .wr_done      (wr_done),
        .pixel_out    (pixel_out),
        .busy         (busy),
        .overrun      (overrun),
        .fifo_enable  (fifo_enable),
        .fifo_din     (fifo_din),
        .fifo_dout    (fifo_dout),
        .fifo_rst_n   (fifo_rst_n)
    );

    // Line store model: head bit on dout, new bit enters at the tail.
    assign fifo_dout = store[0];
    always @(posedge clk) begin
        if (!fifo_rst_n) store <= '0;
        else if (fifo_enable) store <= {fifo_din, store[DEPTH-1:1]};
    end

    always @(posedge clk) begin
        if (fifo_enable) en_cnt++;
        if (wr_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [DEPTH-1:0] obs, input logic [DEPTH-1:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [DEPTH-1:0] mask(input int a, input int b, input int c);
        logic [DEPTH-1:0] m;
        m = '0;
        if (a >= 0) m[a] = 1'b1;
        if (b >= 0) m[b] = 1'b1;
        if (c >= 0) m[c] = 1'b1;
        return m;
    endfunction

    task automatic host_write(input logic [ADDR_W-1:0] a, input logic d);
        int n;
        n = 0;
        while (!wr_ready && n < 1000) begin
            cyc();
            n++;
        end
        check("wr_ready_wait_timeout", (n < 1000), 1'b1);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        cyc();
        wr_req  = 1'b0;
    endtask

    // Counts cycles spent busy in a rotation; optional line_start at ls_at.
    task automatic measure_rotate(input int ls_at, output int n);
        int w;
        w = 0;
        n = 0;
        while (!busy && w < 8) begin
            cyc();
            w++;
        end
        check("rotate_start_timeout", (w < 8), 1'b1);
        while (busy && n < 2000) begin
            if (n == ls_at) line_start = 1'b1;
            cyc();
            line_start = 1'b0;
            if (n == ls_at) begin
                check("rotate_overrun_set", overrun, 1'b1);
                check("rotate_pixel_zero", pixel_out, 1'b0);
            end
            n++;
        end
    endtask

    task automatic do_scan(input int n_ticks, input int gap_at, input logic gap_exp,
                           input int wr_at, input logic [ADDR_W-1:0] a, input logic d,
                           output logic [DEPTH-1:0] pix, output logic [DEPTH-1:0] dn);
        pix = '0;
        dn  = '0;
        line_start = 1'b1;
        cyc();
        line_start = 1'b0;
        check("scan_busy_start", busy, 1'b1);
        for (int i = 0; i < n_ticks; i++) begin
            pix_tick = 1'b1;
            if (i == wr_at) begin
                wr_req  = 1'b1;
                wr_addr = a;
                wr_data = d;
            end
            cyc();
            pix_tick = 1'b0;
            wr_req   = 1'b0;
            pix[i]   = pixel_out;
            dn[i]    = wr_done;
            if (i == DEPTH - 2) check("scan_busy_before_last", busy, 1'b1);
            if (i == gap_at) begin
                cyc();
                check("scan_gap_hold", pixel_out, gap_exp);
            end
        end
    endtask

    initial begin
        logic [DEPTH-1:0] pix;
        logic [DEPTH-1:0] dn;
        int e0;
        int d0;
        int n;

        rst = 1'b1; line_start = 1'b0; pix_tick = 1'b0; blank_window = 1'b0;
        wr_req = 1'b0; wr_addr = '0; wr_data = 1'b0;
        @(negedge clk);
        cyc();
        cyc();
        check("rst_fifo_rst_n", fifo_rst_n, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_pixel", pixel_out, 1'b0);
        check("rst_wr_ready", wr_ready, 1'b1);
        check("rst_wr_done", wr_done, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        rst = 1'b0;
        #1;
        check("fifo_rst_n_release", fifo_rst_n, 1'b1);
        cyc();

        // Empty line scans as zeros; exactly DEPTH shifts.
        e0 = en_cnt;
        do_scan(DEPTH, -1, 1'b0, -1, '0, 1'b0, pix, dn);
        check("scan0_busy_drop", busy, 1'b0);
        check("scan0_shifts", en_cnt - e0, DEPTH);
        check("scan0_pixels", pix, '0);
        cyc();
        check("scan0_pixel_idle", pixel_out, 1'b0);

        // Blanking write: full rotation commits bit 5.
        blank_window = 1'b1;
        host_write(8'd5, 1'b1);
        check("w5_slot_full", wr_ready, 1'b0);
        e0 = en_cnt;
        d0 = done_cnt;
        measure_rotate(-1, n);
        check("w5_rotate_len", n, DEPTH);
        check("w5_rotate_shifts", en_cnt - e0, DEPTH);
        check("w5_done_once", done_cnt - d0, 1);
        check("w5_ready_after", wr_ready, 1'b1);
        blank_window = 1'b0;
        do_scan(DEPTH, 5, 1'b1, -1, '0, 1'b0, pix, dn);
        check("w5_scan_image", pix, mask(5, -1, -1));

        // Write during scan at tick 10 commits when bit 200 passes.
        blank_window = 1'b1;
        e0 = en_cnt;
        do_scan(DEPTH, -1, 1'b0, 10, 8'd200, 1'b1, pix, dn);
        check("w200_scan_image", pix, mask(5, -1, -1));
        check("w200_done_at_200", dn, mask(200, -1, -1));
        cyc(); cyc(); cyc();
        check("w200_no_rotate", busy, 1'b0);
        check("w200_shifts", en_cnt - e0, DEPTH);
        check("w200_ready", wr_ready, 1'b1);
        blank_window = 1'b0;
        do_scan(DEPTH, -1, 1'b0, -1, '0, 1'b0, pix, dn);
        check("w200_next_image", pix, mask(5, 200, -1));

        // No blanking window: write waits; extra request while full is ignored.
        host_write(8'd3, 1'b1);
        e0 = en_cnt;
        cyc(); cyc(); cyc(); cyc(); cyc();
        check("w3_wait_ready", wr_ready, 1'b0);
        check("w3_wait_idle", busy, 1'b0);
        check("w3_wait_no_shift", en_cnt - e0, 0);
        wr_req = 1'b1; wr_addr = 8'd7; wr_data = 1'b1;
        cyc(); cyc();
        wr_req = 1'b0;
        blank_window = 1'b1;
        d0 = done_cnt;
        measure_rotate(-1, n);
        check("w3_rotate_len", n, DEPTH);
        check("w3_done_once", done_cnt - d0, 1);
        check("w3_ready_after", wr_ready, 1'b1);
        blank_window = 1'b0;
        do_scan(DEPTH, -1, 1'b0, -1, '0, 1'b0, pix, dn);
        check("w3_scan_image", pix, mask(3, 5, 200));

        // line_start mid-rotation: sticky overrun, rotation unaltered; clear bit 5.
        blank_window = 1'b1;
        host_write(8'd5, 1'b0);
        check("ovr_pre", overrun, 1'b0);
        measure_rotate(20, n);
        check("ovr_rotate_len", n, DEPTH);
        blank_window = 1'b0;
        cyc(); cyc(); cyc();
        check("ovr_sticky", overrun, 1'b1);
        check("ovr_idle", busy, 1'b0);
        do_scan(DEPTH, -1, 1'b0, -1, '0, 1'b0, pix, dn);
        check("ovr_scan_image", pix, mask(3, 200, -1));
        check("ovr_sticky_after_scan", overrun, 1'b1);

        // Reset mid-scan at tick 100, then the cleared store scans as zeros.
        do_scan(100, -1, 1'b0, -1, '0, 1'b0, pix, dn);
        check("rstmid_partial_image", pix, mask(3, -1, -1));
        pix_tick = 1'b1;
        rst = 1'b1;
        cyc();
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_pixel", pixel_out, 1'b0);
        check("rstmid_fifo_rst_n", fifo_rst_n, 1'b0);
        check("rstmid_overrun", overrun, 1'b0);
        pix_tick = 1'b0;
        rst = 1'b0;
        cyc();
        e0 = en_cnt;
        do_scan(DEPTH, -1, 1'b0, -1, '0, 1'b0, pix, dn);
        check("rstmid_scan_image", pix, '0);
        check("rstmid_scan_shifts", en_cnt - e0, DEPTH);
        check("rstmid_busy_drop", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
